// File: rtl/instruction_decode_pipe.sv
// -----------------------------------------------------------------------------
// instruction_decode_pipe
//
// Decode stage between instruction fetch and execute. It holds a registered
// IF/ID -> EX boundary with a valid/ready handshake. It also holds the
// register file, a write-through bypass from write-back, load-use hazard
// detection and zero/sign immediate extension.
//
// Instruction fields (fixed 16-bit encoding):
//   opcode[15:12]  rs1[11:9]  rd[8:6]  rs2[5:3]  imm[6:0]
// Register index fields are zero-padded or truncated to RA_W bits.
//
// All state changes on the falling edge of clk_n. rst is an asynchronous,
// active-high reset that clears the stage outputs and the register file.
//
// Ports
//   clk_n              in   clock, state updates on falling edge
//   rst                in   asynchronous active-high reset
//   if_valid           in   if_next_addr / if_curr_inst hold a fetched instruction
//   if_next_addr       in   PC+1 of the fetched instruction
//   if_curr_inst       in   fetched instruction word
//   id_ready           out  stage accepts the IF instruction on this edge
//   wb_reg_wea         in   write-back register write enable
//   wb_reg_waddr       in   write-back register index
//   wb_reg_wdata       in   write-back data
//   ex_ready           in   execute consumes id_* on this edge
//   id_valid           out  id_* hold a real instruction
//   id_opcode          out  registered opcode
//   id_next_addr       out  registered PC+1
//   id_register1_data  out  registered rs1 value (bypassed)
//   id_register2_data  out  registered rs2 value (bypassed)
//   id_imm             out  registered extended immediate
//   id_dest_reg_addr   out  registered rd
//   id_stall           out  a load-use bubble is inserted on this edge
// -----------------------------------------------------------------------------
module instruction_decode_pipe #(
  parameter int         DATA_W   = 16,
  parameter int         ADDR_W   = 7,
  parameter int         REG_CNT  = 8,
  parameter bit         IMM_SEXT = 1'b1,
  parameter bit         R0_ZERO  = 1'b0,
  parameter logic [3:0] LOAD_OP  = 4'h8,
  localparam int        RA_W     = (REG_CNT > 1) ? $clog2(REG_CNT) : 1
) (
  input  logic              clk_n,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_next_addr,
  input  logic [15:0]       if_curr_inst,
  output logic              id_ready,
  input  logic              wb_reg_wea,
  input  logic [RA_W-1:0]   wb_reg_waddr,
  input  logic [DATA_W-1:0] wb_reg_wdata,
  input  logic              ex_ready,
  output logic              id_valid,
  output logic [3:0]        id_opcode,
  output logic [ADDR_W-1:0] id_next_addr,
  output logic [DATA_W-1:0] id_register1_data,
  output logic [DATA_W-1:0] id_register2_data,
  output logic [DATA_W-1:0] id_imm,
  output logic [RA_W-1:0]   id_dest_reg_addr,
  output logic              id_stall
);

  // The array is sized to the full index space so that any index is a legal
  // read. Entries at or above REG_CNT are never written and stay 0.
  localparam int RF_DEPTH = 1 << RA_W;

  // ---------------------------------------------------------------------------
  // Field decode
  // ---------------------------------------------------------------------------
  logic [3:0]        dec_opcode;
  logic [RA_W-1:0]   dec_rs1;
  logic [RA_W-1:0]   dec_rs2;
  logic [RA_W-1:0]   dec_rd;
  logic [DATA_W-1:0] dec_imm;

  assign dec_opcode = if_curr_inst[15:12];
  assign dec_rs1    = RA_W'(if_curr_inst[11:9]);
  assign dec_rs2    = RA_W'(if_curr_inst[5:3]);
  assign dec_rd     = RA_W'(if_curr_inst[8:6]);

  generate
    if (IMM_SEXT) begin : g_imm_sext
      assign dec_imm = {{(DATA_W-7){if_curr_inst[6]}}, if_curr_inst[6:0]};
    end else begin : g_imm_zext
      assign dec_imm = {{(DATA_W-7){1'b0}}, if_curr_inst[6:0]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]   regs_q [RF_DEPTH];
  logic [RF_DEPTH-1:0] reg_we;

  // Per-entry write enable. Entries beyond REG_CNT, and entry 0 when it is
  // hard-wired to zero, never take a write.
  genvar gi;
  generate
    for (gi = 0; gi < RF_DEPTH; gi++) begin : g_reg_we
      if ((gi >= REG_CNT) || (R0_ZERO && (gi == 0))) begin : g_no_write
        assign reg_we[gi] = 1'b0;
      end else begin : g_write
        assign reg_we[gi] = wb_reg_wea && (wb_reg_waddr == RA_W'(gi));
      end
    end
  endgenerate

  // Writes do not depend on stall or handshake state. Write-back always lands.
  always_ff @(negedge clk_n or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        if (reg_we[i]) begin
          regs_q[i] <= wb_reg_wdata;
        end
      end
    end
  end

  // Combinational read with write-through. A write on the same edge as a
  // capture is forwarded, so the captured operand is the new value. The
  // zero-register rule is checked last so that it also wins over the bypass.
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;

  always_comb begin
    rd1_data = regs_q[dec_rs1];
    if (wb_reg_wea && (wb_reg_waddr == dec_rs1)) begin
      rd1_data = wb_reg_wdata;
    end
    if (R0_ZERO && (dec_rs1 == '0)) begin
      rd1_data = '0;
    end

    rd2_data = regs_q[dec_rs2];
    if (wb_reg_wea && (wb_reg_waddr == dec_rs2)) begin
      rd2_data = wb_reg_wdata;
    end
    if (R0_ZERO && (dec_rs2 == '0)) begin
      rd2_data = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and hazard
  // ---------------------------------------------------------------------------
  logic              id_valid_q,    id_valid_d;
  logic [3:0]        id_opcode_q,   id_opcode_d;
  logic [ADDR_W-1:0] id_next_q,     id_next_d;
  logic [DATA_W-1:0] id_r1_q,       id_r1_d;
  logic [DATA_W-1:0] id_r2_q,       id_r2_d;
  logic [DATA_W-1:0] id_imm_q,      id_imm_d;
  logic [RA_W-1:0]   id_dest_q,     id_dest_d;

  logic out_fire;
  logic haz;
  logic accept;

  // The output register may load when it is empty or being consumed.
  assign out_fire = !id_valid_q || ex_ready;

  // A load in ID whose destination feeds the incoming instruction cannot
  // forward in time. The incoming instruction waits one slot behind a bubble.
  assign haz = if_valid && id_valid_q && (id_opcode_q == LOAD_OP) &&
               ((id_dest_q == dec_rs1) || (id_dest_q == dec_rs2));

  assign id_ready = out_fire && !haz;
  assign id_stall = out_fire && haz;
  assign accept   = id_ready && if_valid;

  always_comb begin
    id_valid_d  = id_valid_q;
    id_opcode_d = id_opcode_q;
    id_next_d   = id_next_q;
    id_r1_d     = id_r1_q;
    id_r2_d     = id_r2_q;
    id_imm_d    = id_imm_q;
    id_dest_d   = id_dest_q;

    if (out_fire) begin
      if (accept) begin
        id_valid_d  = 1'b1;
        id_opcode_d = dec_opcode;
        id_next_d   = if_next_addr;
        id_r1_d     = rd1_data;
        id_r2_d     = rd2_data;
        id_imm_d    = dec_imm;
        id_dest_d   = dec_rd;
      end else begin
        // Bubble (hazard) or nothing to take. The payload fields hold their
        // old values and only the valid flag drops.
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(negedge clk_n or posedge rst) begin
    if (rst) begin
      id_valid_q  <= 1'b0;
      id_opcode_q <= '0;
      id_next_q   <= '0;
      id_r1_q     <= '0;
      id_r2_q     <= '0;
      id_imm_q    <= '0;
      id_dest_q   <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      id_opcode_q <= id_opcode_d;
      id_next_q   <= id_next_d;
      id_r1_q     <= id_r1_d;
      id_r2_q     <= id_r2_d;
      id_imm_q    <= id_imm_d;
      id_dest_q   <= id_dest_d;
    end
  end

  assign id_valid          = id_valid_q;
  assign id_opcode         = id_opcode_q;
  assign id_next_addr      = id_next_q;
  assign id_register1_data = id_r1_q;
  assign id_register2_data = id_r2_q;
  assign id_imm            = id_imm_q;
  assign id_dest_reg_addr  = id_dest_q;

endmodule
